// File: rtl/overdrive_multimode.sv
// Overdrive stage with gain slew, selectable clip curve, dry/wet mix and output saturation.
// Pipeline: S1 captures sample and gain, S2 clips the scaled sample, S3 mixes and saturates.
// Each sample's mode, threshold and mix travel down the pipe with it.
module overdrive_multimode #(
  parameter int FXP_SIZE  = 16,
  parameter int GAIN_FRAC = 4,
  parameter int GAIN_STEP = 1,
  parameter int MIX_BITS  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic signed [FXP_SIZE-1:0] i_sample,
  input  logic [FXP_SIZE-1:0]        i_gain,
  input  logic [FXP_SIZE-2:0]        i_threshold,
  input  logic [1:0]                 i_mode,
  input  logic [MIX_BITS:0]          i_mix,
  output logic                       o_valid,
  output logic signed [FXP_SIZE-1:0] o_sample,
  output logic                       o_clip
);

  localparam int PW = 2 * FXP_SIZE;
  localparam int RW = 2 * FXP_SIZE + 1;
  localparam int MW = FXP_SIZE + MIX_BITS + 3;
  localparam logic [FXP_SIZE-1:0]          GAIN_UNITY  = FXP_SIZE'(1) << GAIN_FRAC;
  localparam logic [FXP_SIZE-1:0]          GAIN_STEP_U = FXP_SIZE'(GAIN_STEP);
  localparam logic signed [FXP_SIZE+1:0]   GAIN_STEP_S = (FXP_SIZE+2)'(GAIN_STEP);
  localparam logic [MIX_BITS:0]            MIX_FULL    = {1'b1, {MIX_BITS{1'b0}}};

  // Saturate the shifted gain product to PW signed bits (one guard bit above).
  function automatic logic signed [PW-1:0] sat_prod(input logic signed [RW-1:0] v);
    logic signed [PW-1:0] r;
    if (v[RW-1] != v[RW-2]) begin
      if (v[RW-1]) r = {1'b1, {(PW-1){1'b0}}};
      else         r = {1'b0, {(PW-1){1'b1}}};
    end else begin
      r = v[PW-1:0];
    end
    return r;
  endfunction

  // Saturate the mixed value to the output sample width.
  function automatic logic signed [FXP_SIZE-1:0] sat_out(input logic signed [MW-1:0] v);
    logic signed [FXP_SIZE-1:0] r;
    if ((&v[MW-1:FXP_SIZE-1]) || (~|v[MW-1:FXP_SIZE-1])) begin
      r = v[FXP_SIZE-1:0];
    end else if (v[MW-1]) begin
      r = {1'b1, {(FXP_SIZE-1){1'b0}}};
    end else begin
      r = {1'b0, {(FXP_SIZE-1){1'b1}}};
    end
    return r;
  endfunction

  // Stage registers
  logic                       v1_r, v2_r;
  logic signed [FXP_SIZE-1:0] x1_r, x2_r, wet2_r;
  logic [FXP_SIZE-1:0]        g1_r, gain_r;
  logic [FXP_SIZE-2:0]        thr1_r;
  logic [1:0]                 mode1_r, mode2_r;
  logic [MIX_BITS:0]          mix1_r, mix2_r;
  logic                       clip2_r;

  // Combinational nets
  logic signed [FXP_SIZE+1:0] gain_diff_s;
  logic [FXP_SIZE-1:0]        gain_next_s;
  logic signed [RW-1:0]       prod_raw_s, prod_shift_s;
  logic signed [PW-1:0]       p_s;
  logic [PW-1:0]              mag_s, t_s, half_s, hard_y_s, soft_y_s, wet_mag_s;
  logic                       hard_clip_s, soft_clip_s, clip_s, neg_s;
  logic signed [FXP_SIZE-1:0] wet_s;
  logic [MIX_BITS:0]          mix_c_s, dry_w_s;
  logic signed [MW-1:0]       acc_s, acc_shift_s;
  logic signed [FXP_SIZE-1:0] mixed_s;

  assign gain_diff_s = $signed({2'b00, i_gain}) - $signed({2'b00, gain_r});

  // Slew-limited step of the internal gain toward the requested gain.
  always_comb begin
    gain_next_s = gain_r;
    if (gain_diff_s > GAIN_STEP_S) begin
      gain_next_s = gain_r + GAIN_STEP_U;
    end else if (gain_diff_s < -GAIN_STEP_S) begin
      gain_next_s = gain_r - GAIN_STEP_U;
    end else begin
      gain_next_s = i_gain;
    end
  end

  // S1: capture sample with the gain in force before this sample's slew update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r    <= 1'b0;
      x1_r    <= {FXP_SIZE{1'b0}};
      g1_r    <= GAIN_UNITY;
      gain_r  <= GAIN_UNITY;
      thr1_r  <= {(FXP_SIZE-1){1'b0}};
      mode1_r <= 2'd0;
      mix1_r  <= {(MIX_BITS+1){1'b0}};
    end else begin
      v1_r <= i_valid;
      if (i_valid) begin
        x1_r    <= i_sample;
        g1_r    <= gain_r;
        gain_r  <= gain_next_s;
        thr1_r  <= i_threshold;
        mode1_r <= i_mode;
        mix1_r  <= i_mix;
      end
    end
  end

  assign prod_raw_s   = RW'(x1_r) * RW'($signed({1'b0, g1_r}));
  assign prod_shift_s = prod_raw_s >>> GAIN_FRAC;
  assign p_s          = sat_prod(prod_shift_s);
  assign neg_s        = p_s[PW-1];
  assign mag_s        = neg_s ? $unsigned(PW'(0) - p_s) : $unsigned(p_s);

  // Clip curves evaluated on magnitude; sign restored afterwards.
  always_comb begin
    t_s         = PW'(thr1_r);
    half_s      = t_s >> 1;
    hard_y_s    = mag_s;
    hard_clip_s = 1'b0;
    soft_y_s    = mag_s;
    soft_clip_s = 1'b0;
    wet_mag_s   = {PW{1'b0}};
    clip_s      = 1'b0;
    if (mag_s > t_s) begin
      hard_y_s    = t_s;
      hard_clip_s = 1'b1;
    end else begin
      hard_y_s    = mag_s;
      hard_clip_s = 1'b0;
    end
    if (mag_s <= half_s) begin
      soft_y_s    = mag_s;
      soft_clip_s = 1'b0;
    end else if (mag_s < (t_s + half_s)) begin
      soft_y_s    = half_s + ((mag_s - half_s) >> 1);
      soft_clip_s = 1'b1;
    end else begin
      soft_y_s    = t_s;
      soft_clip_s = 1'b1;
    end
    case (mode1_r)
      2'd1: begin
        wet_mag_s = hard_y_s;
        clip_s    = hard_clip_s;
      end
      2'd2: begin
        wet_mag_s = soft_y_s;
        clip_s    = soft_clip_s;
      end
      2'd3: begin
        if (neg_s) begin
          wet_mag_s = soft_y_s;
          clip_s    = soft_clip_s;
        end else begin
          wet_mag_s = hard_y_s;
          clip_s    = hard_clip_s;
        end
      end
      default: begin
        wet_mag_s = {PW{1'b0}};
        clip_s    = 1'b0;
      end
    endcase
    if (neg_s) begin
      wet_s = FXP_SIZE'(0) - $signed(wet_mag_s[FXP_SIZE-1:0]);
    end else begin
      wet_s = $signed(wet_mag_s[FXP_SIZE-1:0]);
    end
  end

  // S2: hold dry sample, clipped wet sample and clip flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r    <= 1'b0;
      x2_r    <= {FXP_SIZE{1'b0}};
      wet2_r  <= {FXP_SIZE{1'b0}};
      clip2_r <= 1'b0;
      mode2_r <= 2'd0;
      mix2_r  <= {(MIX_BITS+1){1'b0}};
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        x2_r    <= x1_r;
        wet2_r  <= wet_s;
        clip2_r <= clip_s;
        mode2_r <= mode1_r;
        mix2_r  <= mix1_r;
      end
    end
  end

  assign mix_c_s     = (mix2_r > MIX_FULL) ? MIX_FULL : mix2_r;
  assign dry_w_s     = MIX_FULL - mix_c_s;
  assign acc_s       = MW'(x2_r) * MW'($signed({1'b0, dry_w_s}))
                     + MW'(wet2_r) * MW'($signed({1'b0, mix_c_s}));
  assign acc_shift_s = acc_s >>> MIX_BITS;
  assign mixed_s     = sat_out(acc_shift_s);

  // S3: registered outputs; bypass mode passes the dry sample untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid  <= 1'b0;
      o_sample <= {FXP_SIZE{1'b0}};
      o_clip   <= 1'b0;
    end else begin
      o_valid <= v2_r;
      if (v2_r) begin
        if (mode2_r == 2'd0) begin
          o_sample <= x2_r;
          o_clip   <= 1'b0;
        end else begin
          o_sample <= mixed_s;
          o_clip   <= clip2_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_overdrive_multimode.sv
// Directed bench for overdrive_multimode: reset, latency, clip curves, gain slew, mix, hold.
module tb_overdrive_multimode;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic signed [15:0] i_sample;
  logic [15:0]        i_gain;
  logic [14:0]        i_threshold;
  logic [1:0]         i_mode;
  logic [8:0]         i_mix;
  logic               o_valid;
  logic signed [15:0] o_sample;
  logic               o_clip;

  int n_tests = 0;
  int n_fail  = 0;

  overdrive_multimode #(
    .FXP_SIZE(16), .GAIN_FRAC(4), .GAIN_STEP(1), .MIX_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sample(i_sample), .i_gain(i_gain),
    .i_threshold(i_threshold), .i_mode(i_mode), .i_mix(i_mix),
    .o_valid(o_valid), .o_sample(o_sample), .o_clip(o_clip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic signed [15:0] x, input logic [15:0] g,
                       input logic [14:0] t, input logic [1:0] m, input logic [8:0] mx);
    i_valid = v; i_sample = x; i_gain = g; i_threshold = t; i_mode = m; i_mix = mx;
  endtask

  // Drives one sample at a negedge and checks it emerges exactly three cycles later.
  task automatic send_check(input logic signed [15:0] x, input logic [15:0] g,
                            input logic [14:0] t, input logic [1:0] m, input logic [8:0] mx,
                            input int exp_s, input int exp_c, input string tag);
    drive(1'b1, x, g, t, m, mx);
    @(negedge clk);
    i_valid = 1'b0;
    chk({tag, "_lat1"}, int'(o_valid), 0);
    @(negedge clk);
    chk({tag, "_lat2"}, int'(o_valid), 0);
    @(negedge clk);
    chk({tag, "_valid"}, int'(o_valid), 1);
    chk({tag, "_sample"}, o_sample, exp_s);
    chk({tag, "_clip"}, int'(o_clip), exp_c);
  endtask

  // Streams bypass samples back-to-back so the internal gain reaches the target.
  task automatic settle(input logic [15:0] g);
    for (int k = 0; k < 60; k++) begin
      drive(1'b1, 16'sd0, g, 15'd4096, 2'd0, 9'd256);
      @(negedge clk);
    end
    i_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("settle_out", o_sample, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'sd0, 16'd16, 15'd4096, 2'd1, 9'd256);
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_sample", o_sample, 0);
    chk("rst_clip", int'(o_clip), 0);
    rst = 1'b1;
    @(negedge clk);

    // Preload a nonzero output so the reset clear is observable.
    send_check(16'sd500, 16'd16, 15'd4096, 2'd0, 9'd256, 500, 0, "pre");

    // Test 1: reset with samples in flight; gain must return to unity.
    drive(1'b1, 16'sd1000, 16'd64, 15'd4096, 2'd1, 9'd256);
    @(negedge clk);
    drive(1'b1, 16'sd1100, 16'd64, 15'd4096, 2'd1, 9'd256);
    @(negedge clk);
    drive(1'b1, 16'sd1200, 16'd64, 15'd4096, 2'd1, 9'd256);
    #2 rst = 1'b0;
    i_valid = 1'b0;
    @(negedge clk);
    chk("t1_rst_valid", int'(o_valid), 0);
    chk("t1_rst_sample", o_sample, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_no_pulse", int'(o_valid), 0);
    end
    send_check(16'sd100, 16'd64, 15'd4096, 2'd1, 9'd256, 100, 0, "t1_gain16");

    // Test 2: hard clip at x4 gain.
    settle(16'd64);
    send_check(16'sd2000, 16'd64, 15'd4096, 2'd1, 9'd256, 4096, 1, "t2_hard");

    // Test 3: soft clip regions at unity gain.
    settle(16'd16);
    send_check(16'sd1000, 16'd16, 15'd4096, 2'd2, 9'd256, 1000, 0, "t3_lin");
    send_check(16'sd4096, 16'd16, 15'd4096, 2'd2, 9'd256, 3072, 1, "t3_knee");
    send_check(-16'sd7000, 16'd16, 15'd4096, 2'd2, 9'd256, -4096, 1, "t3_neg");

    // Test 4: gain ramp 16 -> 32, one LSB per sample, back-to-back.
    for (int i = 0; i < 22; i++) begin
      if (i < 20) drive(1'b1, 16'sd100, 16'd32, 15'd4096, 2'd1, 9'd256);
      else        i_valid = 1'b0;
      @(negedge clk);
      if (i >= 2) begin
        chk("t4_valid", int'(o_valid), 1);
        chk("t4_ramp", o_sample, (100 * (((16 + i - 2) < 32) ? (16 + i - 2) : 32)) / 16);
      end
    end
    @(negedge clk);
    chk("t4_end_valid", int'(o_valid), 0);
    chk("t4_end_hold", o_sample, 200);

    // Test 5: mix amounts.
    settle(16'd16);
    send_check(16'sd8000, 16'd16, 15'd4096, 2'd1, 9'd128, 6048, 1, "t5_mix128");
    send_check(16'sd8000, 16'd16, 15'd4096, 2'd1, 9'd300, 4096, 1, "t5_mix300");
    send_check(16'sd8000, 16'd16, 15'd4096, 2'd1, 9'd0, 8000, 1, "t5_mix0");
    send_check(-16'sd8000, 16'd16, 15'd4096, 2'd1, 9'd1, -7985, 1, "t5_floor");

    // Test 6: asymmetric curve, bypass and holding between strobes.
    send_check(16'sd6000, 16'd16, 15'd4096, 2'd3, 9'd256, 4096, 1, "t6_pos");
    send_check(-16'sd5000, 16'd16, 15'd4096, 2'd3, 9'd256, -3524, 1, "t6_neg");
    send_check(-16'sd32768, 16'd16, 15'd4096, 2'd0, 9'd128, -32768, 0, "t6_bypass");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_gap_valid", int'(o_valid), 0);
      chk("t6_gap_hold", o_sample, -32768);
    end

    // Zero threshold: wet collapses to zero, clip flags any nonzero magnitude.
    send_check(16'sd50, 16'd16, 15'd0, 2'd1, 9'd256, 0, 1, "t0_hard");
    send_check(16'sd0, 16'd16, 15'd0, 2'd2, 9'd256, 0, 0, "t0_zero");
    send_check(-16'sd50, 16'd16, 15'd0, 2'd2, 9'd256, 0, 1, "t0_soft");
    @(negedge clk);
    chk("t0_hold_clip", int'(o_clip), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
